// File: rtl/ntt_pkg.sv
// Shared constants and types for the ntt result readout path.
package ntt_pkg;

  localparam int NTT_N      = 1536;
  localparam int NTT_AW     = 11;
  localparam int NTT_DW     = 14;
  localparam int NTT_RD_LAT = 2;
  localparam int NTT_DEPTH  = 4;

  typedef logic [NTT_DW-1:0] coeff_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/ntt_rd_fifo.sv
// Small first-word-fall-through capture FIFO with occupancy count and flush.
module ntt_rd_fifo
  import ntt_pkg::*;
#(
  parameter int W     = NTT_DW + 1,
  parameter int DEPTH = NTT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees the slot on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Storage is not reset, so an empty FIFO presents zero rather than stale entries.
  assign dout = empty ? '0 : mem[rd_ptr];

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/ntt_result_reader.sv
// Sweeps the ntt core read port and streams the returned coefficients with
// credit-limited issue so backpressure never overruns the capture FIFO.
module ntt_result_reader
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int AW     = NTT_AW,
  parameter int DW     = NTT_DW,
  parameter int RD_LAT = NTT_RD_LAT,
  parameter int DEPTH  = NTT_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ntt_valid,
  input  logic          clear,
  output logic [AW-1:0] ntt_addr,
  input  logic [DW-1:0] ntt_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  // Stage 0 lines up with ntt_addr; the remaining RD_LAT stages track the core's read latency.
  localparam int PL = RD_LAT + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(PL + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  state_t        state;
  logic [AW-1:0] issue_cnt;
  tag_t          pipe [PL];
  logic [OW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [DW:0]   fifo_dout;
  logic          fifo_empty;
  logic          credit_ok;
  logic          issue;
  logic          pop;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < PL; i++) begin
      outstanding = outstanding + OW'(pipe[i].valid);
    end
  end

  // A beat popped on this edge frees a slot, which keeps full throughput at m_ready=1.
  assign credit_ok = (SW'(outstanding) + SW'(fifo_count)) < (SW'(DEPTH) + SW'(pop));
  assign issue     = (state == ST_READ) && credit_ok && !clear;
  assign pop       = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else begin
      pipe[0].valid <= issue;
      pipe[0].last  <= issue && (issue_cnt == AW'(N - 1));
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      ntt_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      issue_cnt <= '0;
      ntt_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ntt_valid) begin
            state     <= ST_READ;
            busy      <= 1'b1;
            issue_cnt <= '0;
          end
        end
        ST_READ: begin
          if (issue) begin
            ntt_addr <= issue_cnt;
            if (issue_cnt == AW'(N - 1)) state <= ST_DRAIN;
            else issue_cnt <= issue_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ntt_rd_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (pipe[PL-1].valid),
    .din   ({pipe[PL-1].last, ntt_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_dout[DW-1:0];
  assign m_last  = fifo_dout[DW];

endmodule
